// File: rtl/lookahead_multiport_ram.sv
// Single-write, multi-read lookahead RAM. Each read port owns a copy of the
// array, which keeps every copy a simple dual-port block RAM. A write and a
// read of the same address on the same edge return the newly written bytes.
// An optional sweep writes zero to every word after reset.

// Per-port array copy, registered read and byte-wise lookahead merge
module lookahead_multiport_ram_port #(
   parameter int DEPTH         = 16,
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       mem_we,
   input  logic [ADDRESS_WIDTH-1:0]   mem_wa,
   input  logic [DATA_WIDTH-1:0]      mem_wd,
   input  logic [DATA_WIDTH/8-1:0]    mem_be,
   input  logic [DATA_WIDTH-1:0]      byp_data,
   input  logic [ADDRESS_WIDTH-1:0]   rd_address,
   input  logic                       force_zero,
   output logic [DATA_WIDTH-1:0]      rd_readdata
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam logic [ADDRESS_WIDTH:0] DEPTH_L = (ADDRESS_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_q;
   logic                  rd_ok;
   logic                  rd_ok_q;
   logic [BYTES-1:0]      byp_q;

   assign rd_ok = ({1'b0, rd_address} < DEPTH_L);

   // Byte-enabled array write; registered read sees pre-write contents
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < BYTES; b++) begin
            if (mem_be[b]) mem[mem_wa][8*b +: 8] <= mem_wd[8*b +: 8];
         end
      end
      rd_q <= mem[rd_address];
   end

   // Per-byte bypass flags and address-range flag for the read in flight
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_ok_q <= 1'b0;
         byp_q   <= '0;
      end else begin
         rd_ok_q <= rd_ok;
         byp_q   <= (mem_we && rd_ok && (mem_wa == rd_address)) ? mem_be : '0;
      end
   end

   // Merge bypassed bytes over the array read; out-of-range reads give zero
   always_comb begin
      rd_readdata = '0;
      for (int b = 0; b < BYTES; b++) begin
         if (byp_q[b])     rd_readdata[8*b +: 8] = byp_data[8*b +: 8];
         else if (rd_ok_q) rd_readdata[8*b +: 8] = rd_q[8*b +: 8];
      end
      if (force_zero) rd_readdata = '0;
   end
endmodule

module lookahead_multiport_ram #(
   parameter int DEPTH          = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_WIDTH  = 4,
   parameter int NUM_READ_PORTS = 2,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic [ADDRESS_WIDTH-1:0]               wr_address,
   input  logic [DATA_WIDTH-1:0]                  wr_writedata,
   input  logic [DATA_WIDTH/8-1:0]                wr_byteenable,
   input  logic                                   wr_write,
   output logic                                   wr_waitrequest,
   input  logic [NUM_READ_PORTS*ADDRESS_WIDTH-1:0] rd_address,
   output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]    rd_readdata
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam bit CLEAR = (CLEAR_ON_RESET != 0);
   localparam logic [ADDRESS_WIDTH:0] DEPTH_L = (ADDRESS_WIDTH + 1)'(DEPTH);

   logic [ADDRESS_WIDTH-1:0] clear_count;
   logic                     sweep;
   logic                     ext_wr;
   logic                     mem_we;
   logic [ADDRESS_WIDTH-1:0] mem_wa;
   logic [DATA_WIDTH-1:0]    mem_wd;
   logic [BYTES-1:0]         mem_be;
   logic [DATA_WIDTH-1:0]    byp_data_q;

   // Sweep zero-writes take the write port until waitrequest drops; the
   // sweep write is also bypassed so the last cleared word reads clean
   always_comb begin
      sweep  = CLEAR && wr_waitrequest && reset_n;
      ext_wr = wr_write && !wr_waitrequest && reset_n &&
               ({1'b0, wr_address} < DEPTH_L);
      mem_we = sweep || ext_wr;
      mem_wa = wr_address;
      mem_wd = wr_writedata;
      mem_be = ext_wr ? wr_byteenable : '0;
      if (sweep) begin
         mem_wa = clear_count;
         mem_wd = '0;
         mem_be = '1;
      end
   end

   // Waitrequest / clear sweep counter and registered bypass data
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_waitrequest <= 1'b1;
         clear_count    <= ADDRESS_WIDTH'(DEPTH - 1);
         byp_data_q     <= '0;
      end else begin
         byp_data_q <= mem_wd;
         if (wr_waitrequest) begin
            if (CLEAR && (clear_count != '0)) clear_count <= clear_count - 1'b1;
            else                              wr_waitrequest <= 1'b0;
         end
      end
   end

   for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
      lookahead_multiport_ram_port #(
         .DEPTH         (DEPTH),
         .DATA_WIDTH    (DATA_WIDTH),
         .ADDRESS_WIDTH (ADDRESS_WIDTH)
      ) u_port (
         .clk         (clk),
         .reset_n     (reset_n),
         .mem_we      (mem_we),
         .mem_wa      (mem_wa),
         .mem_wd      (mem_wd),
         .mem_be      (mem_be),
         .byp_data    (byp_data_q),
         .rd_address  (rd_address[p*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
         .force_zero  (wr_waitrequest),
         .rd_readdata (rd_readdata[p*DATA_WIDTH +: DATA_WIDTH])
      );
   end
endmodule

// File: tb/tb_lookahead_multiport_ram.sv
// Scoreboard bench: instance A (DEPTH 16, 2 ports, clear sweep) and
// instance B (DEPTH 12, 3 ports, no clear). Stimulus pushes expectations
// tagged with the edge they refer to; the monitor checks them at negedge.
module tb_lookahead_multiport_ram;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Instance A
   logic        a_rst = 1'b0;
   logic [3:0]  a_wa  = '0;
   logic [31:0] a_wd  = '0;
   logic [3:0]  a_be  = '0;
   logic        a_wr  = 1'b0;
   logic        a_wreq;
   logic [7:0]  a_rda = '0;
   logic [63:0] a_rdd;

   lookahead_multiport_ram #(
      .DEPTH(16), .DATA_WIDTH(32), .ADDRESS_WIDTH(4),
      .NUM_READ_PORTS(2), .CLEAR_ON_RESET(1)
   ) u_a (
      .clk(clk), .reset_n(a_rst), .wr_address(a_wa), .wr_writedata(a_wd),
      .wr_byteenable(a_be), .wr_write(a_wr), .wr_waitrequest(a_wreq),
      .rd_address(a_rda), .rd_readdata(a_rdd)
   );

   // Instance B
   logic        b_rst = 1'b0;
   logic [3:0]  b_wa  = '0;
   logic [31:0] b_wd  = '0;
   logic [3:0]  b_be  = '0;
   logic        b_wr  = 1'b0;
   logic        b_wreq;
   logic [11:0] b_rda = '0;
   logic [95:0] b_rdd;

   lookahead_multiport_ram #(
      .DEPTH(12), .DATA_WIDTH(32), .ADDRESS_WIDTH(4),
      .NUM_READ_PORTS(3), .CLEAR_ON_RESET(0)
   ) u_b (
      .clk(clk), .reset_n(b_rst), .wr_address(b_wa), .wr_writedata(b_wd),
      .wr_byteenable(b_be), .wr_write(b_wr), .wr_waitrequest(b_wreq),
      .rd_address(b_rda), .rd_readdata(b_rdd)
   );

   typedef struct {
      int          cyc;
      int          inst;
      int          kind;   // 0 = wr_waitrequest, 1 = rd_readdata
      int          port;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Expectation for the edge that samples the inputs driven now
   task automatic push(input int inst, input int kind, input int port,
                       input logic [31:0] v, input string nm);
      exp_t e;
      e.cyc = cyc + 1; e.inst = inst; e.kind = kind; e.port = port;
      e.exp = v; e.name = nm;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] actual(input int inst, input int kind, input int port);
      if (inst == 0) return (kind == 0) ? {31'd0, a_wreq} : a_rdd[port*32 +: 32];
      return (kind == 0) ? {31'd0, b_wreq} : b_rdd[port*32 +: 32];
   endfunction

   // Monitor: compare every expectation due at this edge
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         logic [31:0] act;
         e = q.pop_front();
         act = actual(e.inst, e.kind, e.port);
         n_cmp++;
         if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s inst%0d port%0d edge %0d: got %h want %h",
                     e.name, e.inst, e.port, cyc, act, e.exp);
         end
      end
   end

   logic [31:0] mdl [12];

   initial begin
      // ---------------- Instance A: reset and clear sweep ----------------
      tick();
      for (int i = 0; i < 3; i++) begin
         push(0, 0, 0, 32'd1, "rst_wreq");
         push(0, 1, 0, 32'd0, "rst_rd0");
         push(0, 1, 1, 32'd0, "rst_rd1");
         tick();
      end
      a_rst = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         push(0, 0, 0, 32'd1, "sweep1_wreq");
         tick();
      end
      a_rst = 1'b0;                       // reset at sweep edge 7
      push(0, 0, 0, 32'd1, "midsweep_rst_wreq");
      push(0, 1, 0, 32'd0, "midsweep_rst_rd0");
      tick();
      a_rst = 1'b1;
      a_rda = {4'd3, 4'd3};
      for (int e = 1; e <= 16; e++) begin
         a_wr = (e <= 3);                 // ignored while waitrequest is high
         a_wa = 4'd3; a_wd = 32'hDEADBEEF; a_be = 4'hF;
         push(0, 0, 0, (e < 16) ? 32'd1 : 32'd0, "sweep2_wreq");
         if (e < 16) push(0, 1, 1, 32'd0, "sweep_rd_forced");
         tick();
      end
      a_wr = 1'b0;
      for (int a = 0; a < 16; a++) begin
         a_rda = {4'(15 - a), 4'(a)};
         push(0, 1, 0, 32'd0, "clear_rd0");
         push(0, 1, 1, 32'd0, "clear_rd1");
         tick();
      end

      // ---------------- Instance A: writes and lookahead ----------------
      a_rda = {4'd6, 4'd5};
      a_wr = 1'b1; a_wa = 4'd5; a_wd = 32'h11223344; a_be = 4'hF;
      push(0, 1, 0, 32'h11223344, "byp_full_p0");
      push(0, 1, 1, 32'h00000000, "addr6_clear_p1");
      tick();
      a_wa = 4'd6; a_wd = 32'h55667788;
      push(0, 1, 0, 32'h11223344, "array_p0");
      push(0, 1, 1, 32'h55667788, "byp_full_p1");
      tick();
      a_wa = 4'd5; a_wd = 32'hAABBCCDD; a_be = 4'b0101;
      push(0, 1, 0, 32'h11BB33DD, "byp_partial_p0");
      push(0, 1, 1, 32'h55667788, "other_port_p1");
      tick();
      a_wr = 1'b0;
      push(0, 1, 0, 32'h11BB33DD, "after_byp_p0");
      push(0, 1, 1, 32'h55667788, "after_byp_p1");
      tick();
      a_wr = 1'b1; a_wd = 32'hFFFFFFFF; a_be = 4'b0000;
      push(0, 1, 0, 32'h11BB33DD, "be_zero_p0");
      tick();
      a_rda = {4'd5, 4'd5}; a_wd = 32'h01020304; a_be = 4'hF;
      push(0, 1, 0, 32'h01020304, "dual_byp_p0");
      push(0, 1, 1, 32'h01020304, "dual_byp_p1");
      tick();
      a_wr = 1'b0; a_rst = 1'b0;          // reset mid-traffic
      push(0, 0, 0, 32'd1, "midtraffic_rst_wreq");
      push(0, 1, 0, 32'd0, "midtraffic_rst_rd0");
      tick();
      a_rst = 1'b1;

      // ---------------- Instance B: no-clear mode ----------------
      push(1, 0, 0, 32'd1, "b_rst_wreq");
      for (int p = 0; p < 3; p++) push(1, 1, p, 32'd0, "b_rst_rd");
      tick();
      b_rst = 1'b1;
      push(1, 0, 0, 32'd0, "b_noclear_wreq");
      tick();
      for (int a = 0; a < 12; a++) begin
         b_wr = 1'b1; b_wa = 4'(a); b_wd = 32'hA5C30000 | 32'(a * 257); b_be = 4'hF;
         mdl[a] = b_wd;
         b_rda = {4'd12, 4'd13, 4'(a)};
         push(1, 1, 0, mdl[a], "b_init_byp");
         push(1, 1, 1, 32'd0, "b_oor13");
         push(1, 1, 2, 32'd0, "b_oor12");
         tick();
      end
      b_wr = 1'b0;
      b_rda = {4'd11, 4'd0, 4'd5};
      push(1, 1, 0, mdl[5],  "b_readback5");
      push(1, 1, 1, mdl[0],  "b_readback0");
      push(1, 1, 2, mdl[11], "b_readback11");
      tick();
      for (int it = 0; it < 300; it++) begin
         int wa;
         wa   = $urandom_range(0, 15);
         b_wr = 1'($urandom_range(0, 1));
         b_wa = 4'(wa);
         b_be = 4'($urandom_range(0, 15));
         b_wd = $urandom;
         if (b_wr && wa < 12)
            for (int b = 0; b < 4; b++)
               if (b_be[b]) mdl[wa][8*b +: 8] = b_wd[8*b +: 8];
         for (int p = 0; p < 3; p++) begin
            int ra;
            ra = (p == 0 && it % 4 == 0) ? wa : $urandom_range(0, 15);
            b_rda[p*4 +: 4] = 4'(ra);
            push(1, 1, p, (ra < 12) ? mdl[ra] : 32'd0, "b_rand");
         end
         tick();
      end
      b_wr = 1'b0;
      tick();
      tick();

      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
